// File: rtl/sha_model_pipe.sv
// Behavioural stand-in for the SHA-256 double-hash core: throttled accept, sequence tagging,
// pseudo-hash (seed + tag) through a fixed-latency pipe. Optional macro SHA_MODEL_FLUSH_EN.
module sha_model_pipe #(
  parameter int unsigned COUNTBITS = 6,
  parameter int unsigned DELAY_C   = 4,
  parameter int unsigned II        = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 validIn,
  input  logic                 newBlockIn,
  input  logic [351:0]         initialState,
  output logic                 readyOut,
  output logic                 validOut,
  output logic                 newBlockOut,
  output logic [255:0]         hash,
  output logic [31:0]          difficulty,
  output logic [COUNTBITS-1:0] seqOut
);

  localparam int unsigned HASH_W = 256;
  localparam int unsigned DIFF_W = 32;
  localparam int unsigned THR_W  = (II > 1) ? $clog2(II) : 1;
  localparam logic [THR_W-1:0] THR_LOAD = THR_W'(II - 1);

  logic [COUNTBITS-1:0] seq_q, seq_d;
  logic [THR_W-1:0]     thr_q, thr_d;
  logic                 ready_q, ready_d;

  logic [DELAY_C-1:0]   vld_q, vld_d;
  logic [DELAY_C-1:0]   nb_q, nb_d;
  logic [HASH_W-1:0]    hash_q [DELAY_C];
  logic [HASH_W-1:0]    hash_d [DELAY_C];
  logic [DIFF_W-1:0]    diff_q [DELAY_C];
  logic [DIFF_W-1:0]    diff_d [DELAY_C];
  logic [COUNTBITS-1:0] tag_q  [DELAY_C];
  logic [COUNTBITS-1:0] tag_d  [DELAY_C];

  logic                 accept_c;
  logic [COUNTBITS-1:0] tag_c;

  always_comb begin
    accept_c = validIn && ready_q;
    tag_c    = newBlockIn ? '0 : seq_q;
  end

  // Sequence counter and initiation-interval throttle
  always_comb begin
    seq_d = seq_q;
    thr_d = thr_q;
    if (accept_c) begin
      seq_d = newBlockIn ? COUNTBITS'(1) : seq_q + COUNTBITS'(1);
      thr_d = THR_LOAD;
    end else if (thr_q != '0) begin
      thr_d = thr_q - THR_W'(1);
    end
    ready_d = (thr_d == '0);
  end

  // Pipe shift; bubbles carry zeroed data so idle outputs stay at their reset values
  always_comb begin
    vld_d  = '0;
    nb_d   = '0;
    hash_d = hash_q;
    diff_d = diff_q;
    tag_d  = tag_q;

    vld_d[0]  = accept_c;
    nb_d[0]   = accept_c && newBlockIn;
    hash_d[0] = accept_c ? initialState[255:0] + HASH_W'(tag_c) : '0;
    diff_d[0] = accept_c ? initialState[351:320] : '0;
    tag_d[0]  = accept_c ? tag_c : '0;

    for (int unsigned i = 1; i < DELAY_C; i++) begin
      vld_d[i]  = vld_q[i-1];
      nb_d[i]   = nb_q[i-1];
      hash_d[i] = hash_q[i-1];
      diff_d[i] = diff_q[i-1];
      tag_d[i]  = tag_q[i-1];
    end

`ifdef SHA_MODEL_FLUSH_EN
    // A new block retires every older in-flight entry on the same edge
    if (accept_c && newBlockIn) begin
      for (int unsigned i = 1; i < DELAY_C; i++) begin
        vld_d[i] = 1'b0;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seq_q   <= '0;
      thr_q   <= '0;
      ready_q <= 1'b1;
      vld_q   <= '0;
      nb_q    <= '0;
      for (int unsigned i = 0; i < DELAY_C; i++) begin
        hash_q[i] <= '0;
        diff_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else begin
      seq_q   <= seq_d;
      thr_q   <= thr_d;
      ready_q <= ready_d;
      vld_q   <= vld_d;
      nb_q    <= nb_d;
      hash_q  <= hash_d;
      diff_q  <= diff_d;
      tag_q   <= tag_d;
    end
  end

  assign readyOut    = ready_q;
  assign validOut    = vld_q[DELAY_C-1];
  assign newBlockOut = nb_q[DELAY_C-1];
  assign hash        = hash_q[DELAY_C-1];
  assign difficulty  = diff_q[DELAY_C-1];
  assign seqOut      = tag_q[DELAY_C-1];

endmodule
